// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller and the ALU:
// FSM states, opcode/funct values, ALU operation codes and mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_JR       = 4'd11
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_ADDU = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_SUBU = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_SLLV = 4'b1100;
    localparam logic [3:0] ALU_SRLV = 4'b1101;
    localparam logic [3:0] ALU_SRAV = 4'b1110;

    // Datapath mux selects
    localparam logic [1:0] SRC_A_PC  = 2'b00;
    localparam logic [1:0] SRC_A_RS  = 2'b01;
    localparam logic [1:0] SRC_A_RT  = 2'b10;
    localparam logic [1:0] SRC_B_RT  = 2'b00;
    localparam logic [1:0] SRC_B_4   = 2'b01;
    localparam logic [1:0] SRC_B_IMM = 2'b10;
    localparam logic [1:0] SRC_B_BR  = 2'b11;
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REG_A  = 2'b11;
    localparam logic [1:0] DST_RT    = 2'b00;
    localparam logic [1:0] DST_RD    = 2'b01;
    localparam logic [1:0] DST_RA    = 2'b10;
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    // R-type funct codes that go through EXEC_R (JR is handled separately)
    function automatic logic funct_is_alu(input logic [5:0] f);
        case (f)
            F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
            F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Shifts by shamt take rt as A and the immediate field as B
    function automatic logic funct_is_shamt(input logic [5:0] f);
        return (f == F_SLL) || (f == F_SRL) || (f == F_SRA);
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle. There is no valid/ready handshake here:
// the datapath presents op/funct/zero continuously and the controller
// answers combinationally every cycle; master is the controller side.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic [2:0] zero;
    logic [3:0] alu_ctr;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output alu_ctr, alu_src_a, alu_src_b, ext_op,
        output pc_write, ir_write, reg_write, mem_write,
        output pc_src, reg_dst, mem_to_reg, illegal, state
    );

    modport slave (
        output op, funct, zero,
        input  alu_ctr, alu_src_a, alu_src_b, ext_op,
        input  pc_write, ir_write, reg_write, mem_write,
        input  pc_src, reg_dst, mem_to_reg, illegal, state
    );
endinterface

// File: rtl/mc_ctrl_alu_dec.sv
// ALU decoder: per-state ALU operation, operand selects and immediate
// extension mode. Purely combinational; the FSM lives in mc_ctrl.
module alu_dec
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctr,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op
);

    function automatic logic [3:0] r_alu(input logic [5:0] f);
        case (f)
            F_ADD:   return ALU_ADD;
            F_ADDU:  return ALU_ADDU;
            F_SUB:   return ALU_SUB;
            F_SUBU:  return ALU_SUBU;
            F_AND:   return ALU_AND;
            F_OR:    return ALU_OR;
            F_XOR:   return ALU_XOR;
            F_NOR:   return ALU_NOR;
            F_SLL:   return ALU_SLL;
            F_SRL:   return ALU_SRL;
            F_SRA:   return ALU_SRA;
            F_SLLV:  return ALU_SLLV;
            F_SRLV:  return ALU_SRLV;
            F_SRAV:  return ALU_SRAV;
            default: return ALU_ADD;
        endcase
    endfunction

    // Select ALU function and operands for the current state
    always_comb begin
        alu_ctr   = ALU_ADD;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_RT;
        ext_op    = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b = SRC_B_4;
            end
            S_DECODE: begin
                // branch target PC+4+(simm<<2) parked in ALUOut
                alu_src_b = SRC_B_BR;
                ext_op    = 1'b1;
            end
            S_EXEC_R: begin
                alu_ctr = r_alu(funct);
                if (funct_is_shamt(funct)) begin
                    alu_src_a = SRC_A_RT;
                    alu_src_b = SRC_B_IMM;
                    ext_op    = 1'b1;
                end else begin
                    alu_src_a = SRC_A_RS;
                    alu_src_b = SRC_B_RT;
                end
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RS;
                alu_src_b = SRC_B_IMM;
                case (op)
                    OP_ADDI:  begin alu_ctr = ALU_ADD;  ext_op = 1'b1; end
                    OP_ADDIU: begin alu_ctr = ALU_ADDU; ext_op = 1'b1; end
                    OP_ANDI:  alu_ctr = ALU_AND;
                    OP_ORI:   alu_ctr = ALU_OR;
                    OP_XORI:  alu_ctr = ALU_XOR;
                    OP_LUI:   alu_ctr = ALU_LUI;
                    default:  alu_ctr = ALU_ADD;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = SRC_A_RS;
                alu_src_b = SRC_B_IMM;
                ext_op    = 1'b1;
            end
            S_BRANCH: begin
                alu_ctr   = ALU_SUB;
                alu_src_a = SRC_A_RS;
                alu_src_b = SRC_B_RT;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: state register, next-state logic and
// write strobes. ALU-side controls come from alu_dec. All outputs are
// forced to zero while rst_n is low.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    mc_ctrl_if.master   bus
);

    state_t     state_q;
    state_t     state_d;

    logic [3:0] dec_alu_ctr;
    logic [1:0] dec_src_a;
    logic [1:0] dec_src_b;
    logic       dec_ext_op;

    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       illegal;

    alu_dec u_alu_dec (
        .state     (state_q),
        .op        (bus.op),
        .funct     (bus.funct),
        .alu_ctr   (dec_alu_ctr),
        .alu_src_a (dec_src_a),
        .alu_src_b (dec_src_b),
        .ext_op    (dec_ext_op)
    );

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and write strobes
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        pc_src     = PC_ALU;
        reg_dst    = DST_RT;
        mem_to_reg = WB_ALUOUT;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_FETCH;
                case (bus.op)
                    OP_RTYPE: begin
                        if (bus.funct == F_JR) begin
                            state_d = S_JR;
                        end else if (funct_is_alu(bus.funct)) begin
                            state_d = S_EXEC_R;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                        state_d = S_EXEC_I;
                    OP_LW, OP_SW:
                        state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                        state_d = S_BRANCH;
                    OP_J, OP_JAL:
                        state_d = S_JUMP;
                    default:
                        illegal = 1'b1;
                endcase
            end
            S_EXEC_R, S_EXEC_I: begin
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = (bus.op == OP_RTYPE) ? DST_RD : DST_RT;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                state_d = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = WB_MDR;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                pc_src = PC_ALUOUT;
                case (bus.op)
                    OP_BEQ:  pc_write = bus.zero[0];
                    OP_BNE:  pc_write = ~bus.zero[0];
                    OP_BLEZ: pc_write = bus.zero[0] | bus.zero[2];
                    OP_BGTZ: pc_write = bus.zero[1];
                    default: pc_write = 1'b0;
                endcase
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
                if (bus.op == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = DST_RA;
                    mem_to_reg = WB_PC;
                end
                state_d = S_FETCH;
            end
            S_JR: begin
                pc_write = 1'b1;
                pc_src   = PC_REG_A;
                state_d  = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Drive the bus; everything reads as zero while reset is held
    always_comb begin
        bus.alu_ctr    = rst_n ? dec_alu_ctr : 4'd0;
        bus.alu_src_a  = rst_n ? dec_src_a   : 2'd0;
        bus.alu_src_b  = rst_n ? dec_src_b   : 2'd0;
        bus.ext_op     = rst_n & dec_ext_op;
        bus.pc_write   = rst_n & pc_write;
        bus.ir_write   = rst_n & ir_write;
        bus.reg_write  = rst_n & reg_write;
        bus.mem_write  = rst_n & mem_write;
        bus.pc_src     = rst_n ? pc_src      : 2'd0;
        bus.reg_dst    = rst_n ? reg_dst     : 2'd0;
        bus.mem_to_reg = rst_n ? mem_to_reg  : 2'd0;
        bus.illegal    = rst_n & illegal;
        bus.state      = rst_n ? state_q     : 4'd0;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 op  input  6  IR[31:26], held stable by the external IR outside FETCH.
REQ-004 funct  input  6  IR[5:0].
REQ-005 zero  input  3  ALU flags of the current ALU result: [0] result==0, [1] positive non-zero, [2] negative.
REQ-006 alu_ctr  output  4  ALU operation code.
REQ-007 alu_src_a  output  2  A operand select: 00 PC, 01 reg A (rs), 10 reg B (rt).
REQ-008 alu_src_b  output  2  B operand select: 00 reg B (rt), 01 constant 4, 10 extended imm, 11 extended imm<<2.
REQ-009 ext_op  output  1  imm extension: 1 sign, 0 zero.
REQ-010 pc_write, ir_write, reg_write, mem_write  output  1 each  write strobes.
REQ-011 pc_src  output  2  next PC: 00 ALU result, 01 ALUOut, 10 {PC[31:28],IR[25:0],2'b00}, 11 reg A.
REQ-012 reg_dst  output  2  00 rt, 01 rd, 10 $31.
REQ-013 mem_to_reg  output  2  00 ALUOut, 01 MDR, 10 PC.
REQ-014 illegal  output  1  one-cycle pulse on unsupported op/funct.
REQ-015 state  output  4  current state, for debug.

Function
REQ-016 States: FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, JR.
REQ-017 FETCH: ir_write=1, pc_write=1, alu_src_a=00, alu_src_b=01, alu_ctr=0000, pc_src=00; next DECODE.
REQ-018 DECODE: alu_src_a=00, alu_src_b=11, ext_op=1, alu_ctr=0000 (branch target into ALUOut); next state by op/funct.
REQ-019 R-type (op 000000): funct 001000 -> JR; other supported funct -> EXEC_R -> ALU_WB (reg_dst=01).
REQ-020 alu_ctr by funct: add 100000->0000, addu 100001->0001, sub 100010->0010, subu 100011->0011, and 100100->0100, or 100101->0101, xor 100110->0110, nor 100111->0111, sll 000000->1001, srl 000010->1010, sra 000011->1011, sllv 000100->1100, srlv 000110->1101, srav 000111->1110.
REQ-021 EXEC_R operands: sll/srl/sra use alu_src_a=10, alu_src_b=10, ext_op=1 (shamt in imm[10:6]); all others use alu_src_a=01, alu_src_b=00.
REQ-022 I-type ALU -> EXEC_I -> ALU_WB (reg_dst=00), alu_src_a=01, alu_src_b=10: addi 001000->0000 sign, addiu 001001->0001 sign, andi 001100->0100 zero, ori 001101->0101 zero, xori 001110->0110 zero, lui 001111->1000.
REQ-023 ALU_WB: reg_write=1, mem_to_reg=00; next FETCH.
REQ-024 lw 100011: MEM_ADDR (alu_ctr 0000, src_a 01, src_b 10, sign) -> MEM_RD -> MEM_WB (reg_write, reg_dst=00, mem_to_reg=01) -> FETCH.
REQ-025 sw 101011: MEM_ADDR -> MEM_WR (mem_write=1) -> FETCH.
REQ-026 beq/bne/blez/bgtz (000100/000101/000110/000111) -> BRANCH: alu_ctr=0010, src_a 01, src_b 00, pc_src=01; pc_write = zero[0] / ~zero[0] / zero[0]|zero[2] / zero[1] respectively; overflow not corrected; next FETCH.
REQ-027 j 000010 / jal 000011 -> JUMP: pc_write=1, pc_src=10; jal also reg_write=1, reg_dst=10, mem_to_reg=10; next FETCH.
REQ-028 JR: pc_write=1, pc_src=11; next FETCH.
REQ-029 Unsupported op or funct in DECODE: illegal=1 for that cycle, no strobes, next FETCH.
REQ-030 Cycle counts: R/I-ALU 4, lw 5, sw 4, branch 3, j/jal/jr 3.
REQ-031 Outputs are combinational from state, op, funct, zero; strobes are 0 in every state not listed as asserting them.

Reset
REQ-032 rst_n low at a clock edge forces state to FETCH regardless of current state, including mid-instruction.
REQ-033 While rst_n is low all strobes and illegal are 0; other outputs are 0.
REQ-034 First FETCH strobes assert in the first cycle with rst_n high.

Structure
REQ-035 A shared package holds state encoding, opcode/funct constants and alu_ctr constants, all shared with the ALU.
REQ-036 One sub-module, alu_dec, maps (state, op, funct) to alu_ctr, operand selects and ext_op; the FSM and strobes stay in mc_ctrl.

Verification
REQ-037 add (op 0, funct 100000) after reset -> states FETCH, DECODE, EXEC_R, ALU_WB; alu_ctr 0000 in EXEC_R; reg_write and reg_dst=01 only in ALU_WB.
REQ-038 lw (op 100011) -> 5 cycles; mem_to_reg=01 and reg_write only in cycle 5; sw (101011) -> mem_write only in cycle 4.
REQ-039 beq with zero=001 -> pc_write=1 and pc_src=01 in BRANCH; zero=010 -> pc_write=0; bgtz with zero=010 -> pc_write=1.
REQ-040 sll (funct 000000) -> alu_ctr 1001, alu_src_a=10, alu_src_b=10; srav (000111) -> 1110, alu_src_a=01, alu_src_b=00.
REQ-041 jal (000011) -> JUMP with reg_dst=10, mem_to_reg=10, pc_src=10; op 111111 -> illegal pulse in DECODE, then FETCH.
REQ-042 rst_n low in MEM_RD -> FETCH next cycle with no reg_write; ori -> ext_op=0, alu_ctr 0101.
